rgb_gray_binary_pipe: RTL
=========================

Name: rgb_gray_binary_pipe

Overview:
- Parametrised, pipelined successor to the display-path colour/gray/binary stage.
- Converts an RGB video stream to one of four output modes: passthrough, gray, binary threshold, or contrast stretch.
- Mode and threshold are updated only at frame boundaries.
- Counts thresholded foreground pixels per frame for downstream keystone/auto-threshold logic.

Parameters:
DW, 8, bits per colour channel (output pixel is 3*DW)
XYW, 12, width of pixel coordinates
CNT_W, 22, width of per-frame foreground counter (saturating)
TH_DEFAULT, 40, threshold shadow value after reset
VS_POL, 1, active level of vs; frame start is the transition into the active level

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
i_hs  in  1  hsync
i_vs  in  1  vsync
i_de  in  1  data enable
i_x  in  XYW  pixel X
i_y  in  XYW  pixel Y
i_data  in  3*DW  {R,G,B}
mode_set  in  2  0 pass, 1 gray, 2 binary, 3 stretch
threshold_set  in  DW  binary threshold request
o_hs  out  1  hsync delayed by 3
o_vs  out  1  vsync delayed by 3
o_de  out  1  de delayed by 3
o_x  out  XYW  X delayed by 3
o_y  out  XYW  Y delayed by 3
o_data  out  3*DW  processed pixel
th_flag  out  1  binary decision, aligned with o_data
o_fg_cnt  out  CNT_W  foreground count of the last complete frame
o_fg_valid  out  1  one-cycle strobe when o_fg_cnt updates

Behaviour:
- Interface timing: one clock; reset asynchronous, active-low.
- Reset values: all outputs 0. Shadow mode = 0. Shadow threshold = TH_DEFAULT. Counter = 0. frame_seen = 0.
- Pipeline: fixed 3-cycle latency for every output including sync, x/y and th_flag. No stall or backpressure. Pipeline registers advance every cycle regardless of de.
- S1 registers the products R*76, G*150 and B*30, each DW+8 bits.
- S2 registers gray = (sum >> 8), truncated to DW bits. The coefficients sum to 256, so no overflow occurs.
- S3 registers the mode mux:
  - pass: i_data.
  - gray: {g,g,g}.
  - binary: all-ones if g >= th, otherwise 0.
  - stretch: {s,s,s}, with Q = 2^(DW-2):
    - g < Q: s = g/2.
    - g < 3Q: s = Q/2 + ((g-Q)*3)/2.
    - else: s = 7Q/2 + (g-3Q)/2.
  - All stretch divisions truncate. For DW=8: 0→0, 63→31, 64→32, 191→222, 192→224, 255→255.
- th_flag = (g >= th) in every mode.
- Frame-start detection: vs_d is the registered i_vs. Frame start fs = (i_vs == VS_POL) && (vs_d != VS_POL), computed at the input side.
- Shadow update: on fs, the mode and threshold shadows load mode_set and threshold_set. Changes to these inputs between frame starts have no effect. A pixel already in the pipeline uses the shadow value it observed at S2.
- Foreground counter:
  - Increments on S3 when the delayed de = 1 and th_flag = 1, in every mode.
  - Saturates at 2^CNT_W - 1.
- On fs:
  - The counter copies to o_fg_cnt, then clears.
  - o_fg_valid pulses for 1 cycle.
  - The pulse is suppressed on the first fs after reset (frame_seen = 0 there; it is then set).
  - If a foreground pixel falls on the fs cycle, its count goes to the new frame.
- Reset mid-frame: everything returns to reset values immediately. The partial frame's count is discarded.
- If fs never occurs, the shadows keep their reset values.

Optional Feature:
- Macro: RGB_GRAY_BIN_HYST_EN.
- When defined:
  - A port hyst (in, DW) is added, shadowed on fs like threshold.
  - Binary decision uses line hysteresis:
    - A per-line state bit sets when g >= th.
    - While set, the bit stays set while g >= th - hyst (the subtraction saturates at 0).
    - The bit clears when g drops below th - hyst.
    - The bit clears on every falling edge of the delayed de.
  - th_flag, binary output and the counter all use this decision.
- When not defined: the plain compare g >= th; no hyst port.

Decomposition:
- Package rgb_gray_pkg holds:
  - mode enum: MODE_PASS, MODE_GRAY, MODE_BIN, MODE_STRETCH.
  - coefficient constants: 76, 150, 30.
  - PIPE_LAT = 3.
- One sub-module, gray_stretch_lut: combinational piecewise stretch for width DW, instantiated in S3.

Test Plan:
- Mode 1, DW=8, pixel {255,0,0} → o_data {75,75,75} (19380>>8) three cycles later. o_de, o_x, o_y are delayed by exactly 3.
- Mode 2, th=128: gray 127 → o_data 0, th_flag 0. Gray 128 → 0xFFFFFF, th_flag 1.
- Threshold change mid-frame: threshold_set 40→200 mid-line → no effect until the next vs edge; the new frame then uses 200.
- Counting: frame with 100 de pixels, 37 with gray ≥ th → at next fs, o_fg_cnt = 37 and o_fg_valid high 1 cycle. The first fs after reset gives no strobe.
- Stretch sweep of g = 0, 63, 64, 191, 192, 255 → 0, 31, 32, 222, 224, 255.
- Assert rst_n low mid-line → all outputs 0 at once. Next frame's count excludes pre-reset pixels. With RGB_GRAY_BIN_HYST_EN, th=100, hyst=20, gray sequence 110, 85, 79 → flags 1, 1, 0.

Source files
------------

// File: rtl/rgb_gray_pkg.sv
`default_nettype none
//============================================================================
// Package : rgb_gray_pkg
// Desc    : Shared types and constants for the RGB/gray/binary pipeline.
// Rev     : 1.0  initial release
//============================================================================
package rgb_gray_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_BIN     = 2'd2,
        MODE_STRETCH = 2'd3
    } mode_e;

    // Luma weights; they sum to 256 so the weighted sum never overflows DW+8 bits.
    localparam logic [7:0] COEF_R = 8'd76;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd30;

    localparam int PIPE_LAT = 3;

endpackage
`default_nettype wire

// File: rtl/gray_stretch_lut.sv
`default_nettype none
//============================================================================
// Module : gray_stretch_lut
// Desc   : Combinational three-segment contrast stretch of a DW-bit gray value.
// Rev    : 1.0  initial release
//============================================================================
module gray_stretch_lut #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_g,
    output logic [DW-1:0] o_s
);

    localparam logic [DW-1:0] C_Q    = DW'(1 << (DW - 2));
    localparam logic [DW-1:0] C_3Q   = DW'(3 << (DW - 2));
    localparam logic [DW-1:0] C_Q_H  = DW'(1 << (DW - 3));
    localparam logic [DW-1:0] C_7Q_H = DW'(7 << (DW - 3));

    logic [DW-1:0] w_d;

    // floor(3d/2) == d + floor(d/2), which keeps the middle segment in DW bits.
    always_comb begin
        w_d = '0;
        if (i_g < C_Q) begin
            o_s = i_g >> 1;
        end else if (i_g < C_3Q) begin
            w_d = i_g - C_Q;
            o_s = C_Q_H + w_d + (w_d >> 1);
        end else begin
            o_s = C_7Q_H + ((i_g - C_3Q) >> 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_gray_binary_pipe.sv
`default_nettype none
//============================================================================
// Module : rgb_gray_binary_pipe
// Desc   : 3-stage RGB -> pass/gray/binary/stretch pipe with per-frame
//          foreground counter. Macro RGB_GRAY_BIN_HYST_EN adds line hysteresis.
// Rev    : 1.0  initial release
//============================================================================
module rgb_gray_binary_pipe
    import rgb_gray_pkg::*;
#(
    parameter int DW         = 8,
    parameter int XYW        = 12,
    parameter int CNT_W      = 22,
    parameter int TH_DEFAULT = 40,
    parameter bit VS_POL     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_de,
    input  logic [XYW-1:0]    i_x,
    input  logic [XYW-1:0]    i_y,
    input  logic [3*DW-1:0]   i_data,
    input  logic [1:0]        mode_set,
    input  logic [DW-1:0]     threshold_set,
`ifdef RGB_GRAY_BIN_HYST_EN
    input  logic [DW-1:0]     hyst,
`endif
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_de,
    output logic [XYW-1:0]    o_x,
    output logic [XYW-1:0]    o_y,
    output logic [3*DW-1:0]   o_data,
    output logic              th_flag,
    output logic [CNT_W-1:0]  o_fg_cnt,
    output logic              o_fg_valid
);

    localparam int SBW = 3 + 2 * XYW;

    // Sideband {hs, vs, de, x, y} shift line, one entry per pipe stage.
    logic [SBW-1:0]   sb_q [PIPE_LAT];
    logic [SBW-1:0]   sb_d [PIPE_LAT];

    logic             vs_d_q;
    mode_e            mode_sh_q, mode_sh_d;
    logic [DW-1:0]    th_sh_q, th_sh_d;

    logic [DW+7:0]    prod_r_q, prod_g_q, prod_b_q;
    logic [DW+7:0]    prod_r_d, prod_g_d, prod_b_d;
    logic [3*DW-1:0]  data1_q, data2_q, o_data_q, o_data_d;
    logic [DW-1:0]    gray_q, gray_d;
    mode_e            s2_mode_q;
    logic [DW-1:0]    s2_th_q;
    logic             th_flag_q, th_flag_d;

    logic [CNT_W-1:0] cnt_q, cnt_d, fg_cnt_q, fg_cnt_d;
    logic             fg_valid_q, fg_valid_d;
    logic             frame_seen_q, frame_seen_d;

    logic [DW+7:0]    w_sum;
    logic [DW-1:0]    w_stretch;
    logic             w_fs, w_dec, w_de_s2, w_fg_hit;

`ifdef RGB_GRAY_BIN_HYST_EN
    logic [DW-1:0]    hyst_sh_q, hyst_sh_d, s2_hyst_q, w_th_lo;
    logic             hyst_st_q, hyst_st_d;
`endif

    gray_stretch_lut #(.DW(DW)) u_stretch (
        .i_g (gray_q),
        .o_s (w_stretch)
    );

    assign w_fs     = (i_vs == VS_POL) && (vs_d_q != VS_POL);
    assign w_de_s2  = sb_q[PIPE_LAT-2][2*XYW];
    assign w_fg_hit = o_de && th_flag_q;

    always_comb begin
        sb_d[0] = {i_hs, i_vs, i_de, i_x, i_y};
        for (int k = 1; k < PIPE_LAT; k++) begin
            sb_d[k] = sb_q[k-1];
        end

        prod_r_d = {8'b0, i_data[3*DW-1:2*DW]} * {{DW{1'b0}}, COEF_R};
        prod_g_d = {8'b0, i_data[2*DW-1:DW]}   * {{DW{1'b0}}, COEF_G};
        prod_b_d = {8'b0, i_data[DW-1:0]}      * {{DW{1'b0}}, COEF_B};

        w_sum  = prod_r_q + prod_g_q + prod_b_q;
        gray_d = DW'(w_sum >> 8);

        mode_sh_d = w_fs ? mode_e'(mode_set) : mode_sh_q;
        th_sh_d   = w_fs ? threshold_set     : th_sh_q;

`ifdef RGB_GRAY_BIN_HYST_EN
        hyst_sh_d = w_fs ? hyst : hyst_sh_q;
        w_th_lo   = (s2_th_q > s2_hyst_q) ? (s2_th_q - s2_hyst_q) : '0;
        w_dec     = hyst_st_q ? (gray_q >= w_th_lo) : (gray_q >= s2_th_q);
        // Holding the state only while de is high clears it at every line end.
        hyst_st_d = w_de_s2 && w_dec;
`else
        w_dec     = (gray_q >= s2_th_q);
`endif

        th_flag_d = w_dec;
        case (s2_mode_q)
            MODE_PASS: o_data_d = data2_q;
            MODE_GRAY: o_data_d = {3{gray_q}};
            MODE_BIN:  o_data_d = w_dec ? {3*DW{1'b1}} : '0;
            default:   o_data_d = {3{w_stretch}};
        endcase

        cnt_d        = cnt_q;
        fg_cnt_d     = fg_cnt_q;
        fg_valid_d   = 1'b0;
        frame_seen_d = frame_seen_q;
        if (w_fs) begin
            if (frame_seen_q) begin
                fg_cnt_d   = cnt_q;
                fg_valid_d = 1'b1;
            end
            frame_seen_d = 1'b1;
            // A hit landing on the frame-start cycle belongs to the new frame.
            cnt_d = w_fg_hit ? CNT_W'(1) : '0;
        end else if (w_fg_hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                sb_q[k] <= '0;
            end
            vs_d_q       <= 1'b0;
            mode_sh_q    <= MODE_PASS;
            th_sh_q      <= DW'(TH_DEFAULT);
            prod_r_q     <= '0;
            prod_g_q     <= '0;
            prod_b_q     <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            gray_q       <= '0;
            s2_mode_q    <= MODE_PASS;
            s2_th_q      <= '0;
            o_data_q     <= '0;
            th_flag_q    <= 1'b0;
            cnt_q        <= '0;
            fg_cnt_q     <= '0;
            fg_valid_q   <= 1'b0;
            frame_seen_q <= 1'b0;
`ifdef RGB_GRAY_BIN_HYST_EN
            hyst_sh_q    <= '0;
            s2_hyst_q    <= '0;
            hyst_st_q    <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                sb_q[k] <= sb_d[k];
            end
            vs_d_q       <= i_vs;
            mode_sh_q    <= mode_sh_d;
            th_sh_q      <= th_sh_d;
            prod_r_q     <= prod_r_d;
            prod_g_q     <= prod_g_d;
            prod_b_q     <= prod_b_d;
            data1_q      <= i_data;
            data2_q      <= data1_q;
            gray_q       <= gray_d;
            s2_mode_q    <= mode_sh_q;
            s2_th_q      <= th_sh_q;
            o_data_q     <= o_data_d;
            th_flag_q    <= th_flag_d;
            cnt_q        <= cnt_d;
            fg_cnt_q     <= fg_cnt_d;
            fg_valid_q   <= fg_valid_d;
            frame_seen_q <= frame_seen_d;
`ifdef RGB_GRAY_BIN_HYST_EN
            hyst_sh_q    <= hyst_sh_d;
            s2_hyst_q    <= hyst_sh_q;
            hyst_st_q    <= hyst_st_d;
`endif
        end
    end

    assign {o_hs, o_vs, o_de, o_x, o_y} = sb_q[PIPE_LAT-1];
    assign o_data     = o_data_q;
    assign th_flag    = th_flag_q;
    assign o_fg_cnt   = fg_cnt_q;
    assign o_fg_valid = fg_valid_q;

endmodule
`default_nettype wire
